// File: rtl/sm_add_pkg.sv
// Shared types and helpers for the sign-magnitude adder arbiter.
// Optional overflow output is enabled by SM_ADD_OVF_EN.
package sm_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam logic SIGN_POS = 1'b0;

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude add/subtract with zero-sign normalisation.
// SM_ADD_OVF_EN exposes the carry-out of same-sign additions.
module sm_add_core
  import sm_add_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sa_i,
  input  logic         sb_i,
  output logic [N-1:0] mag_o,
`ifdef SM_ADD_OVF_EN
  output logic         ovf_o,
`endif
  output logic         sign_o
);

  logic         gt;
  logic [N-1:0] mx;
  logic [N-1:0] mn;
  logic [N-1:0] diff;
  logic [N:0]   sum;

  assign gt   = a_i > b_i;
  assign mx   = gt ? a_i : b_i;
  assign mn   = gt ? b_i : a_i;
  assign diff = mx - mn;
  assign sum  = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    mag_o  = sum[N-1:0];
    sign_o = sa_i;
    if (sa_i != sb_i) begin
      mag_o = diff;
      // no negative zero
      if (diff == '0)
        sign_o = SIGN_POS;
      else
        sign_o = gt ? sa_i : sb_i;
    end
  end

`ifdef SM_ADD_OVF_EN
  assign ovf_o = (sa_i == sb_i) & sum[N];
`else
  logic unused_carry;
  assign unused_carry = sum[N];
`endif

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder among NREQ agents.
// Define SM_ADD_OVF_EN to add the registered res_ovf output.
module sm_add_arbiter
  import sm_add_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int NREQ = 2,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   sign_a,
  input  logic [NREQ-1:0]   sign_b,
  input  logic [NREQ*N-1:0] a,
  input  logic [NREQ*N-1:0] b,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [N-1:0]      res_mag,
`ifdef SM_ADD_OVF_EN
  output logic              res_ovf,
`endif
  output logic              res_sign
);

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           sa_q;
  logic           sb_q;

  logic [IDW-1:0] win;
  logic           any_req;
  logic           take;
  logic [N-1:0]   core_mag;
  logic           core_sign;
`ifdef SM_ADD_OVF_EN
  logic           core_ovf;
`endif

  // search starts one past the last winner
  always_comb begin
    win     = ptr_q;
    any_req = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_req && req[(int'(ptr_q) + k) % NREQ]) begin
        any_req = 1'b1;
        win     = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign take = (state_q == IDLE) && any_req;

  assign gnt = (take && reset_n)
             ? ({{(NREQ-1){1'b0}}, 1'b1} << win)
             : '0;

  sm_add_core #(
    .N(N)
  ) u_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .sa_i   (sa_q),
    .sb_i   (sb_q),
    .mag_o  (core_mag),
`ifdef SM_ADD_OVF_EN
    .ovf_o  (core_ovf),
`endif
    .sign_o (core_sign)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_mag   <= '0;
      res_sign  <= 1'b0;
`ifdef SM_ADD_OVF_EN
      res_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            a_q     <= a[int'(win)*N +: N];
            b_q     <= b[int'(win)*N +: N];
            sa_q    <= sign_a[win];
            sb_q    <= sign_b[win];
            id_q    <= win;
            ptr_q   <= win;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_mag   <= core_mag;
          res_sign  <= core_sign;
          res_id    <= id_q;
`ifdef SM_ADD_OVF_EN
          res_ovf   <= core_ovf;
`endif
          res_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Self-checking bench for sm_add_arbiter: timeline model plus directed ops.
// Checks res_ovf too when SM_ADD_OVF_EN is defined.
module tb_sm_add_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              res_ready = 1'b1;
  logic [NREQ-1:0]   req       = '0;
  logic [NREQ-1:0]   sign_a    = '0;
  logic [NREQ-1:0]   sign_b    = '0;
  logic [NREQ*N-1:0] a         = '0;
  logic [NREQ*N-1:0] b         = '0;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [N-1:0]      res_mag;
  logic              res_sign;
`ifdef SM_ADD_OVF_EN
  logic              res_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_add_arbiter #(
    .N    (N),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_mag   (res_mag),
`ifdef SM_ADD_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .res_sign  (res_sign)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int id;
    int mag;
    int sign;
    int ovf;
    int show;
  } res_t;

  res_t q[$];
  int   cyc     = 0;
  int   mptr    = NREQ - 1;
  int   next_ok = 0;
  int   w;
  int   exp_g;
  bit   vis;

  function automatic res_t sm_sum(int id, int sa, int ma, int sb, int mb);
    res_t r;
    int   s;
    r.id  = id;
    r.ovf = 0;
    if (sa == sb) begin
      r.mag  = (ma + mb) % (1 << N);
      r.sign = sa;
      r.ovf  = ((ma + mb) >= (1 << N)) ? 1 : 0;
    end else begin
      s      = (sa ? -ma : ma) + (sb ? -mb : mb);
      r.mag  = (s < 0) ? -s : s;
      r.sign = (s < 0) ? 1 : 0;
    end
    r.show = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_out", int'({res_id, res_mag, res_sign}), 0);
      q.delete();
      mptr    = NREQ - 1;
      next_ok = 0;
    end else begin
      exp_g = 0;
      if (q.size() == 0 && cyc >= next_ok && req != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(mptr + k) % NREQ])
            w = (mptr + k) % NREQ;
        exp_g = 1 << w;
        q.push_back(sm_sum(w, int'(sign_a[w]), int'(a[w*N +: N]),
                           int'(sign_b[w]), int'(b[w*N +: N])));
        q[q.size()-1].show = cyc + 2;
        mptr    = w;
        next_ok = 1 << 30;
      end
      chk("gnt", int'(gnt), exp_g);
      vis = (q.size() > 0) && (cyc >= q[0].show);
      chk("res_valid", int'(res_valid), int'(vis));
      if (vis) begin
        chk("res_id", int'(res_id), q[0].id);
        chk("res_mag", int'(res_mag), q[0].mag);
        chk("res_sign", int'(res_sign), q[0].sign);
`ifdef SM_ADD_OVF_EN
        chk("res_ovf", int'(res_ovf), q[0].ovf);
`endif
        if (res_ready) begin
          void'(q.pop_front());
          next_ok = cyc + 1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_op(int id, bit sa, int ma, bit sb, int mb);
    sign_a[id]     = sa;
    sign_b[id]     = sb;
    a[id*N +: N]   = N'(ma);
    b[id*N +: N]   = N'(mb);
  endtask

  task automatic wait_gnt(int id);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt[id]) break;
    end
    chk($sformatf("gnt%0d_seen", id), int'(n < 20), 1);
  endtask

  task automatic expect_res(int id, int mag, int sign, int ovf);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    chk("valid_seen", int'(n < 20), 1);
    chk("lit_id", int'(res_id), id);
    chk("lit_mag", int'(res_mag), mag);
    chk("lit_sign", int'(res_sign), sign);
`ifdef SM_ADD_OVF_EN
    chk("lit_ovf", int'(res_ovf), ovf);
`else
    if (ovf < 0) chk("lit_ovf_arg", ovf, 0);
`endif
  endtask

  task automatic run_op(int id, bit sa, int ma, bit sb, int mb,
                        int emag, int esign, int eovf);
    @(posedge clk) #1;
    set_op(id, sa, ma, sb, mb);
    req[id] = 1'b1;
    wait_gnt(id);
    @(posedge clk) #1;
    req[id] = 1'b0;
    set_op(id, !sa, 1, !sb, 14);
    expect_res(id, emag, esign, eovf);
  endtask

  int gid[4];
  int gcy[4];
  int ng;
  int lc;

  initial begin
    req = 2'b11;
    set_op(0, 1'b0, 5, 1'b1, 3);
    set_op(1, 1'b1, 3, 1'b0, 6);
    repeat (3) begin
      @(negedge clk);
      chk("lit_rst_gnt", int'(gnt), 0);
      chk("lit_rst_valid", int'(res_valid), 0);
    end

    @(posedge clk) #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("lit_first_gnt", int'(gnt), 1);
    @(posedge clk) #1;
    req = 2'b10;
    set_op(0, 1'b1, 15, 1'b1, 15);
    expect_res(0, 2, 0, 0);
    wait_gnt(1);
    @(posedge clk) #1;
    req = 2'b00;
    expect_res(1, 3, 0, 0);

    run_op(1, 1'b1, 4, 1'b0, 4, 0, 0, 0);
    run_op(1, 1'b1, 2, 1'b1, 5, 7, 1, 0);
    run_op(0, 1'b0, 9, 1'b0, 9, 2, 0, 1);
    run_op(0, 1'b0, 3, 1'b1, 3, 0, 0, 0);
    run_op(0, 1'b1, 6, 1'b1, 6, 12, 1, 0);
    run_op(1, 1'b1, 15, 1'b0, 1, 14, 1, 0);

    // fairness with both requesters held
    @(posedge clk) #1;
    set_op(0, 1'b0, 1, 1'b0, 2);
    set_op(1, 1'b1, 7, 1'b0, 1);
    req = 2'b11;
    ng = 0;
    lc = 0;
    while (ng < 4 && lc < 40) begin
      @(negedge clk);
      lc++;
      if (gnt != '0) begin
        gid[ng] = gnt[1] ? 1 : 0;
        gcy[ng] = lc;
        ng++;
      end
    end
    chk("fair_count", ng, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fair_id%0d", i), gid[i], i % 2);
      if (i > 0)
        chk($sformatf("fair_gap%0d", i), gcy[i] - gcy[i-1], 3);
    end
    @(posedge clk) #1;
    req = 2'b00;
    repeat (4) @(negedge clk);

    // backpressure, then reset while holding a result
    @(posedge clk) #1;
    res_ready = 1'b0;
    set_op(0, 1'b0, 6, 1'b1, 1);
    req = 2'b01;
    wait_gnt(0);
    @(posedge clk) #1;
    req = 2'b11;
    lc = 0;
    while (!res_valid && lc < 10) begin
      @(negedge clk);
      lc++;
    end
    chk("bp_valid_seen", int'(lc < 10), 1);
    repeat (5) begin
      @(negedge clk);
      chk("lit_bp_valid", int'(res_valid), 1);
      chk("lit_bp_mag", int'(res_mag), 5);
      chk("lit_bp_gnt", int'(gnt), 0);
    end
    @(posedge clk) #1;
    reset_n = 1'b0;
    #1;
    chk("lit_mid_rst_valid", int'(res_valid), 0);
    chk("lit_mid_rst_mag", int'(res_mag), 0);
    @(posedge clk) #1;
    reset_n   = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_gnt", int'(gnt), 1);
    @(posedge clk) #1;
    req = 2'b00;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_add_arbiter.md
Name: sm_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sign-magnitude adder core between NREQ requesters.
- Accepts one operand pair at a time through a req/gnt handshake.
- Computes the sign-magnitude sum in a registered cycle, then presents the result with valid/ready backpressure, tagged with the requester id.
- Sits between several control agents and a single shared sign-magnitude arithmetic resource.

Parameters:
- N, 4, magnitude width of operands and result.
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, $clog2(NREQ), width of the requester id (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; must be held with operands until gnt.
- sign_a  in  NREQ  operand A sign per requester (1 = negative).
- sign_b  in  NREQ  operand B sign per requester.
- a  in  NREQ*N  operand A magnitudes; requester i occupies bits [i*N +: N].
- b  in  NREQ*N  operand B magnitudes, packed the same way.
- gnt  out  NREQ  one-hot, single-cycle acceptance pulse.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_id  out  IDW  index of the requester that owns the result.
- res_mag  out  N  result magnitude.
- res_sign  out  1  result sign.

Behaviour:
- Reset: asynchronous, active-low; one clock; no other reset source.
  - Asserting reset_n low forces state IDLE, gnt=0, res_valid=0, res_id=0, res_mag=0, res_sign=0, rr pointer=NREQ-1 (requester 0 has first priority).
  - Reset mid-operation discards latched operands and any pending result; no gnt is issued while reset_n is low.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req is high, gnt is asserted combinationally for the winner in that cycle. At the clock edge the winner's operands and id are latched, the pointer is set to the winner, and the FSM moves to EXEC. If no req is high, it stays in IDLE with gnt=0.
  - EXEC: the core result is registered into res_mag/res_sign/res_id; res_valid goes to 1; the FSM moves to RESP.
  - RESP: outputs are held stable while res_ready=0. When res_valid && res_ready, the FSM moves to IDLE and res_valid goes to 0 at that edge. No grant is issued in the RESP cycle.
- Latency and throughput: res_valid rises 2 edges after the gnt cycle. Best-case throughput is one operation per 3 cycles.
- Arbitration: round-robin. Search starts at pointer+1 modulo NREQ; the first req found wins. A requester that deasserts req before gnt is simply skipped.
- gnt is never asserted outside IDLE and is at most one-hot.
- Arithmetic on latched operands A/B:
  - gt = (A > B) unsigned; max/min select accordingly.
  - Equal signs: mag = (A + B) mod 2^N; sign = sign_a.
  - Differing signs: mag = max − min; sign = sign of the larger magnitude.
  - Zero result (equal magnitudes with opposite signs): mag=0, sign forced to 0. There is no negative zero.
  - A == B with equal signs: sign = sign_a.
- Simultaneous events: a req arriving in the same cycle as the RESP handshake is served in the next IDLE cycle. Operand changes after gnt have no effect.

Optional Feature:
- Macro: SM_ADD_OVF_EN.
- Defined: adds output port res_ovf (1 bit, reset 0), registered with the result in EXEC. res_ovf = carry-out of the N-bit add when signs are equal, otherwise 0. Magnitude still wraps.
- Undefined: the port is absent and overflow silently wraps modulo 2^N.

Decomposition:
- Shared package sm_add_pkg holds:
  - state enum (IDLE, EXEC, RESP);
  - the requester-id width function;
  - constant SIGN_POS = 1'b0.
- One natural sub-module: sm_add_core, a purely combinational compare/add/subtract with zero-sign normalisation. It is instantiated once in the arbiter.

Test Plan:
- Reset: hold reset_n=0 with req=2'b11 -> gnt=0, res_valid=0, res_mag=0, res_sign=0. Release -> first grant goes to requester 0.
- Single request, mixed signs: req0 with a=5(+), b=3(−) -> gnt[0] pulse. Two edges later res_valid=1, res_mag=2, res_sign=0, res_id=0.
- Sign and zero cases, each sent on req1:
  - a=3(−), b=6(+) -> mag=3, sign=0.
  - a=4(−), b=4(+) -> mag=0, sign=0.
  - a=2(−), b=5(−) -> mag=7, sign=1.
- Fairness: req=2'b11 held with res_ready=1 -> grants alternate 0,1,0,1, each spaced 3 cycles apart.
- Backpressure and reset: hold res_ready=0 for 5 cycles -> result stable, no gnt. Then pull reset_n low in RESP -> res_valid=0 immediately, FSM in IDLE.
- Overflow (macro on): a=9(+), b=9(+) -> res_mag=2, res_sign=0, res_ovf=1. With the macro off -> res_mag=2 and no res_ovf port exists.
